// File: rtl/mux_ip_filter_pkg.sv
// Shared types and constants for the multi-rule IP filter.
// Rule records, pipeline stage bundle, decision states, config opcodes.
package mux_ip_filter_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_MODE  = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h03;

  localparam logic [3:0] LEN_WRITE = 4'd9;
  localparam logic [3:0] LEN_MODE  = 4'd2;
  localparam logic [3:0] LEN_CLEAR = 4'd1;

  localparam logic MODE_REJECT = 1'b0;
  localparam logic MODE_PASS   = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [31:0] ip;
    logic [15:0] port;
  } rule_t;

  typedef struct packed {
    logic        en;
    logic [32:0] data;
  } stage_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_W1,
    S_W2,
    S_FWD,
    S_DROP
  } state_t;

  // Port 0 in a rule matches any destination port.
  function automatic logic rule_hit(
    rule_t       r,
    logic [31:0] ip,
    logic [15:0] port
  );
    return r.valid && (r.ip == ip) &&
           ((r.port == '0) || (r.port == port));
  endfunction

endpackage

// File: rtl/mux_ip_filter_multi_if.sv
// Stream and config bus bundle for the multi-rule IP filter.
// master drives traffic/config, slave is the filter.
interface mux_ip_filter_multi_if #(
  parameter int CNT_W = 16
);
  logic [32:0]      ts_din;
  logic             ts_din_en;
  logic [7:0]       con_din;
  logic             con_din_en;
  logic [32:0]      ts_dout;
  logic             ts_dout_en;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output ts_din, ts_din_en, con_din, con_din_en,
    input  ts_dout, ts_dout_en, pass_cnt, drop_cnt
  );

  modport slave (
    input  ts_din, ts_din_en, con_din, con_din_en,
    output ts_dout, ts_dout_en, pass_cnt, drop_cnt
  );
endinterface

// File: rtl/mux_ip_filter_cfg.sv
// Config byte parser: collects a frame into a shadow record and
// emits one-cycle commit strobes when the frame closes cleanly.
module mux_ip_filter_cfg
  import mux_ip_filter_pkg::*;
#(
  parameter int N_RULES = 8,
  parameter int IDX_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       con_din,
  input  logic             con_din_en,
  output logic             wr_en,
  output logic [IDX_W-1:0] idx,
  output rule_t            rule,
  output logic             clr,
  output logic             mode_wr,
  output logic             mode
);

  localparam logic [7:0] N_MAX = 8'(N_RULES);

  logic [3:0]  cnt;
  logic        en_q;
  logic [7:0]  op;
  logic [7:0]  b1;
  logic        vld;
  logic [31:0] ip;
  logic [15:0] port;
  logic        done;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      en_q <= 1'b0;
      op   <= '0;
      b1   <= '0;
      vld  <= 1'b0;
      ip   <= '0;
      port <= '0;
    end else begin
      en_q <= con_din_en;
      if (con_din_en) begin
        // Saturate so over-long frames never wrap to a legal length.
        if (cnt != 4'hf) cnt <= cnt + 4'd1;
        case (cnt)
          4'd0:                   op   <= con_din;
          4'd1:                   b1   <= con_din;
          4'd2:                   vld  <= con_din[0];
          4'd3, 4'd4, 4'd5, 4'd6: ip   <= {ip[23:0], con_din};
          4'd7, 4'd8:             port <= {port[7:0], con_din};
          default: ;
        endcase
      end else begin
        cnt <= '0;
      end
    end
  end

  assign done = en_q && !con_din_en;

  always_comb begin
    wr_en   = 1'b0;
    clr     = 1'b0;
    mode_wr = 1'b0;
    if (done) begin
      unique case (1'b1)
        op == OP_WRITE: wr_en   = (cnt == LEN_WRITE) && (b1 < N_MAX);
        op == OP_MODE:  mode_wr = (cnt == LEN_MODE);
        op == OP_CLEAR: clr     = (cnt == LEN_CLEAR);
        default: ;
      endcase
    end
  end

  assign idx  = b1[IDX_W-1:0];
  assign mode = b1[0];
  assign rule = '{valid: vld, ip: ip, port: port};

endmodule

// File: rtl/mux_ip_filter_multi.sv
// N-rule (IP, port) packet filter on the TS-over-IP word stream.
// Whole packets pass or drop behind a 3-stage delay line.
module mux_ip_filter_multi
  import mux_ip_filter_pkg::*;
#(
  parameter int N_RULES = 8,
  parameter int IDX_W   = (N_RULES > 1) ? $clog2(N_RULES) : 1,
  parameter int CNT_W   = 16
) (
  input logic                clk,
  input logic                rst,
  mux_ip_filter_multi_if.slave bus
);

  logic             wr_en;
  logic             clr;
  logic             mode_wr;
  logic             mode_in;
  logic [IDX_W-1:0] wr_idx;
  rule_t            wr_rule;

  rule_t            rules [N_RULES];
  logic             mode;
  stage_t           s1, s2, s3;
  state_t           state, state_nx;
  logic             pass_q;
  logic             hit;
  logic             din_hdr;
  logic             din_body;
  logic             dec;
  logic             fwd;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] drop_cnt;

  mux_ip_filter_cfg #(
    .N_RULES (N_RULES),
    .IDX_W   (IDX_W)
  ) u_cfg (
    .clk        (clk),
    .rst        (rst),
    .con_din    (bus.con_din),
    .con_din_en (bus.con_din_en),
    .wr_en      (wr_en),
    .idx        (wr_idx),
    .rule       (wr_rule),
    .clr        (clr),
    .mode_wr    (mode_wr),
    .mode       (mode_in)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_RULES; r++) rules[r] <= '0;
      mode <= MODE_REJECT;
    end else begin
      if (clr) begin
        for (int r = 0; r < N_RULES; r++) rules[r].valid <= 1'b0;
      end else if (wr_en) begin
        rules[wr_idx] <= wr_rule;
      end
      if (mode_wr) mode <= mode_in;
    end
  end

  // With the header in s2, word1 sits in s1 and word2 is on the input.
  always_comb begin
    hit = 1'b0;
    for (int r = 0; r < N_RULES; r++) begin
      if (rule_hit(rules[r], s1.data[31:0], bus.ts_din[15:0])) hit = 1'b1;
    end
  end

  assign din_hdr  = bus.ts_din_en && bus.ts_din[32];
  assign din_body = bus.ts_din_en && !bus.ts_din[32];
  assign dec      = (state == S_W1) && din_body &&
                    ((mode == MODE_PASS) ? hit : !hit);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (din_hdr) state_nx = S_HDR;
      S_HDR:  state_nx = din_hdr ? S_HDR : (din_body ? S_W1 : S_DROP);
      S_W1:   state_nx = din_hdr ? S_HDR : (din_body ? S_W2 : S_DROP);
      S_W2:   state_nx = din_hdr ? S_HDR : (pass_q ? S_FWD : S_DROP);
      S_FWD,
      S_DROP: if (din_hdr) state_nx = S_HDR;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      state    <= S_IDLE;
      pass_q   <= 1'b0;
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      s1    <= '{en: bus.ts_din_en, data: bus.ts_din};
      s2    <= s1;
      s3    <= s2;
      state <= state_nx;
      // Latch as the header steps into s3 so the old tail keeps its verdict.
      if (s2.en && s2.data[32]) pass_q <= dec;
      if (s3.en && s3.data[32]) begin
        if (pass_q) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  assign fwd            = s3.en && pass_q;
  assign bus.ts_dout_en = fwd;
  assign bus.ts_dout    = fwd ? s3.data : '0;
  assign bus.pass_cnt   = pass_cnt;
  assign bus.drop_cnt   = drop_cnt;

endmodule
